// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences an iterative AES-128 encrypt datapath through load, rounds and result handoff.
// Round constants are produced by GF(2^8) doubling, so no lookup table is needed.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       start_valid,
  output logic       start_ready,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       dp_load,
  output logic       key_load,
  output logic       dp_round_en,
  output logic       key_en,
  output logic       dp_final,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;
  localparam logic [2:0] SUB_LAST   = 3'(ROUND_CYCLES - 1);
  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);
  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [2:0] sub_q, sub_d;
  logic [7:0] rcon_q, rcon_d;
  logic       last_sub;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      sub_q   <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sub_q   <= sub_d;
      rcon_q  <= rcon_d;
    end
  end
  // Counters are held at zero outside ROUND, so round/rcon decode cleanly from state.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    sub_d       = sub_q;
    rcon_d      = rcon_q;
    last_sub    = (state_q == ROUND) && (sub_q == SUB_LAST);
    start_ready = (state_q == IDLE) && !abort;
    done_valid  = state_q == DONE;
    dp_load     = state_q == LOAD;
    key_load    = state_q == LOAD;
    dp_round_en = last_sub;
    key_en      = last_sub;
    dp_final    = (state_q == ROUND) && (round_q == ROUND_LAST);
    rcon        = (state_q == ROUND) ? rcon_q : 8'h00;
    round       = (state_q == ROUND) ? round_q : 4'd0;
    busy        = (state_q == LOAD) || (state_q == ROUND);
    if (abort) begin
      state_d = IDLE;
      round_d = '0;
      sub_d   = '0;
      rcon_d  = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = start_valid ? LOAD : IDLE;
        LOAD: begin
          state_d = ROUND;
          round_d = 4'd1;
          sub_d   = '0;
          rcon_d  = 8'h01;
        end
        ROUND: begin
          if (!last_sub) sub_d = sub_q + 3'd1;
          else if (round_q < ROUND_LAST) begin
            sub_d   = '0;
            round_d = round_q + 4'd1;
            rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end else begin
            sub_d   = '0;
            state_d = DONE;
            round_d = '0;
            rcon_d  = '0;
          end
        end
        DONE:    state_d = done_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed vector table plus hand-written multi-cycle sequences for the AES round controller.
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic sv1 = 1'b0, ab1 = 1'b0, dr1 = 1'b0;
  logic sr1, dv1, ld1, kld1, en1, ken1, fin1, busy1;
  logic [7:0] rcon1;
  logic [3:0] round1;
  logic sv3 = 1'b0, ab3 = 1'b0, dr3 = 1'b0;
  logic sr3, dv3, ld3, kld3, en3, ken3, fin3, busy3;
  logic [7:0] rcon3;
  logic [3:0] round3;
  aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(ab1), .start_valid(sv1), .start_ready(sr1),
    .done_valid(dv1), .done_ready(dr1), .dp_load(ld1), .key_load(kld1),
    .dp_round_en(en1), .key_en(ken1), .dp_final(fin1), .rcon(rcon1), .round(round1), .busy(busy1));
  aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .abort(ab3), .start_valid(sv3), .start_ready(sr3),
    .done_valid(dv3), .done_ready(dr3), .dp_load(ld3), .key_load(kld3),
    .dp_round_en(en3), .key_en(ken3), .dp_final(fin3), .rcon(rcon3), .round(round3), .busy(busy3));
  typedef struct {
    logic        sv;
    logic        ab;
    logic        dr;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl[17];
  logic [7:0] rc[10];
  int checks = 0;
  int errors = 0;
  logic [19:0] obs1;
  assign obs1 = {sr1, dv1, ld1, kld1, en1, ken1, fin1, busy1, rcon1, round1};
  function automatic logic [19:0] pk(input logic sr, dv, ld, en, fin, bs, input logic [7:0] rcv, input logic [3:0] rnd);
    return {sr, dv, ld, ld, en, en, fin, bs, rcv, rnd};
  endfunction
  function automatic vec_t mk(input logic sv, ab, dr, input logic [19:0] e);
    vec_t v;
    v.sv = sv;
    v.ab = ab;
    v.dr = dr;
    v.exp = e;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int pulses, first_dv, bad, fins, dv_seen;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    tbl[0] = mk(1, 0, 0, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    tbl[1] = mk(0, 0, 0, pk(0, 0, 1, 0, 0, 1, 8'h00, 4'd0));
    for (int r = 1; r <= 10; r++)
      tbl[r+1] = mk(r == 3, 0, 0, pk(0, 0, 0, 1, r == 10, 1, rc[r-1], 4'(r)));
    tbl[12] = mk(0, 0, 0, pk(0, 1, 0, 0, 0, 0, 8'h00, 4'd0));
    tbl[13] = mk(0, 0, 1, pk(0, 1, 0, 0, 0, 0, 8'h00, 4'd0));
    tbl[14] = mk(0, 0, 0, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    tbl[15] = mk(1, 1, 0, pk(0, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    tbl[16] = mk(0, 0, 0, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    sv1 = 1'b1;
    #3;
    chk("reset_outputs", obs1, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    step();
    step();
    chk("reset_held_edge", obs1, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    sv1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", obs1, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    for (int i = 0; i < 17; i++) begin
      sv1 = tbl[i].sv;
      ab1 = tbl[i].ab;
      dr1 = tbl[i].dr;
      #1;
      chk($sformatf("vec%0d", i), obs1, tbl[i].exp);
      step();
    end
    sv1 = 1'b0; ab1 = 1'b0; dr1 = 1'b0;
    // Result held while the requester stalls.
    sv1 = 1'b1;
    step();
    sv1 = 1'b0;
    for (int k = 0; k < 30 && !dv1; k++) step();
    chk("hold_dv_rise", dv1, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_dv%0d", k), {dv1, sr1}, 2'b10);
      step();
    end
    dr1 = 1'b1;
    #1;
    chk("hold_dv_last", dv1, 1);
    step();
    dr1 = 1'b0;
    chk("hold_release", {dv1, sr1, busy1}, 3'b010);
    // Abort during round 4, then restart.
    sv1 = 1'b1;
    step();
    sv1 = 1'b0;
    for (int k = 0; k < 20 && round1 != 4'd4; k++) step();
    chk("abort_at_r4", round1, 4);
    ab1 = 1'b1;
    #1;
    chk("abort_sr_low", sr1, 0);
    step();
    ab1 = 1'b0;
    #1;
    chk("abort_idle", obs1, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    dv_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (dv1 || busy1) dv_seen++;
      step();
    end
    chk("abort_no_done", dv_seen, 0);
    sv1 = 1'b1;
    step();
    sv1 = 1'b0;
    chk("restart_load", ld1, 1);
    step();
    chk("restart_rcon", {rcon1, round1}, {8'h01, 4'd1});
    for (int k = 0; k < 20 && !dv1; k++) step();
    dr1 = 1'b1;
    step();
    dr1 = 1'b0;
    // Asynchronous reset at round 7, start held through reset.
    sv1 = 1'b1;
    step();
    sv1 = 1'b0;
    for (int k = 0; k < 20 && round1 != 4'd7; k++) step();
    chk("reset_at_r7", round1, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", obs1, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    sv1 = 1'b1;
    step();
    chk("reset_ignores_start", obs1, pk(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    sv1 = 1'b0;
    chk("accept_after_release", obs1, pk(0, 0, 1, 0, 0, 1, 8'h00, 4'd0));
    // Three cycles per round on the second instance.
    chk("rc3_idle", {sr3, busy3, dv3}, 3'b100);
    sv3 = 1'b1;
    step();
    sv3 = 1'b0;
    pulses = 0; first_dv = 0; bad = 0; fins = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1 && !ld3) bad++;
      if (en3) begin
        pulses++;
        if (c != 1 + 3 * pulses) bad++;
        if (pulses <= 10 && rcon3 != rc[pulses-1]) bad++;
      end
      if (fin3) fins++;
      if (dv3 && first_dv == 0) first_dv = c;
      step();
    end
    chk("rc3_pulses", pulses, 10);
    chk("rc3_pulse_timing", bad, 0);
    chk("rc3_final_cycles", fins, 3);
    chk("rc3_done_latency", first_dv, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL expose parameter NUM_ROUNDS, default 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 The block SHALL expose parameter ROUND_CYCLES, default 1, cycles per round for a multi-cycle datapath; legal range 1..8.
REQ-003 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-006 The block SHALL have port start_valid  input  1  requester has plaintext and key ready.
REQ-007 The block SHALL have port start_ready  output  1  controller accepts a new job.
REQ-008 The block SHALL have port done_valid  output  1  ciphertext in datapath is final.
REQ-009 The block SHALL have port done_ready  input  1  requester consumes the ciphertext.
REQ-010 The block SHALL have port dp_load  output  1  datapath captures plaintext XOR key (initial AddRoundKey).
REQ-011 The block SHALL have port key_load  output  1  key register captures cipher key.
REQ-012 The block SHALL have port dp_round_en  output  1  state register captures round output.
REQ-013 The block SHALL have port key_en  output  1  key register captures next round key.
REQ-014 The block SHALL have port dp_final  output  1  datapath bypasses MixColumns.
REQ-015 The block SHALL have port rcon  output  8  round constant for the current key expansion step.
REQ-016 The block SHALL have port round  output  4  current round number.
REQ-017 The block SHALL have port busy  output  1  job in progress.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, ROUND, DONE; all outputs are registered or decoded from state and counters only, with no combinational path from inputs to outputs except start_ready.
REQ-019 start_ready SHALL equal (state==IDLE) AND NOT abort; a job is accepted on a cycle where start_valid AND start_ready.
REQ-020 On accept the FSM SHALL enter LOAD for exactly one cycle, with dp_load=1 and key_load=1.
REQ-021 From LOAD the FSM SHALL enter ROUND with round=1 and sub-cycle counter=0.
REQ-022 In ROUND, each round SHALL last ROUND_CYCLES cycles; dp_round_en and key_en SHALL be 1 only on the last cycle (sub-cycle == ROUND_CYCLES-1).
REQ-023 On that last cycle, the block SHALL increment round if round<NUM_ROUNDS, else enter DONE; the sub-cycle counter wraps to 0.
REQ-024 rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10, generated by GF(2^8) doubling (shift left; XOR 0x1b on carry-out), and SHALL be 00 outside ROUND.
REQ-025 dp_final SHALL be 1 for every cycle of round NUM_ROUNDS and 0 otherwise.
REQ-026 round SHALL be 0 in IDLE, LOAD and DONE.
REQ-027 busy SHALL be 1 in LOAD and ROUND and 0 otherwise.
REQ-028 In DONE, done_valid SHALL be 1 and held until done_ready; on done_valid AND done_ready the FSM SHALL return to IDLE next cycle.
REQ-029 Latency with ROUND_CYCLES=1: accept at cycle T, LOAD at T+1, rounds at T+2..T+11, done_valid first high at T+12; in general, done_valid rises at T+2+NUM_ROUNDS*ROUND_CYCLES.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge, clear the counters, and suppress done_valid; abort takes priority over start_valid and done_ready in the same cycle.
REQ-031 start_valid while not in IDLE SHALL be ignored; it has no effect on counters or outputs.

Reset
REQ-032 While rst_n=0, the FSM SHALL be IDLE and the counters 0; start_ready=1 (abort low), all other outputs 0, rcon=00, round=0.
REQ-033 Reset assertion mid-job SHALL take effect immediately, asynchronously; the first edge after release SHALL behave as IDLE.

Verification
REQ-034 With ROUND_CYCLES=1, a start pulse at T SHALL produce: dp_load/key_load at T+1; dp_round_en at T+2..T+11 with rcon 01..36; dp_final only at T+11; done_valid at T+12.
REQ-035 With ROUND_CYCLES=3, dp_round_en SHALL pulse every 3rd cycle, 10 pulses in total, and done_valid SHALL rise at T+32.
REQ-036 If done_ready is held low for 5 cycles after done_valid, done_valid SHALL stay 1 and start_ready 0; done_ready=1 SHALL return the FSM to IDLE the next cycle.
REQ-037 abort at round 4 SHALL produce: next cycle IDLE, busy=0, round=0, no done_valid; a new start then SHALL restart the sequence at rcon=01.
REQ-038 rst_n low at round 7 SHALL clear all outputs within the same cycle; start_valid held during reset SHALL be accepted on the first edge after release.
REQ-039 Combined with the encrypt datapath, plaintext 3243f6a8885a308d313198a2e0370734 and key 2b7e151628aed2a6abf7158809cf4f3c SHALL yield ciphertext 3925841d02dc09fbdc118597196a0b32.
